// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, one bit per clock, LSB first.
//
// A start request in IDLE (or in DONE, for back-to-back operation) captures
// the operands. RUN then spends exactly WIDTH cycles rippling a borrow through
// the operand bits. The result registers load on the final RUN edge, and a
// one-cycle done pulse follows.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - begin a subtraction (accepted in IDLE or DONE)
//   a, b   - minuend / subtrahend, sampled on the accepting edge
//   busy   - high while a subtraction is in progress (RUN)
//   done   - one-cycle pulse marking a new valid result (DONE)
//   diff   - registered (a - b) mod 2^WIDTH
//   borrow - registered borrow-out, high iff a < b
//   zero   - registered flag, high iff diff == 0
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CNT_W-1:0] cnt;

  logic             load_c;
  logic             step_c;
  logic             finish_c;
  logic             d_c;
  logic             br_next_c;
  logic [WIDTH-1:0] result_c;

  // One full-subtractor slice on the current LSBs.
  always_comb begin
    d_c       = a_sr[0] ^ b_sr[0] ^ br;
    br_next_c = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // Difference bit enters at the MSB so the result is aligned after WIDTH shifts.
    result_c  = {d_c, res_sr[WIDTH-1:1]};
  end

  // Next-state and datapath control.
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    finish_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored here.
        step_c = 1'b1;
        if (cnt == LAST_BIT) begin
          finish_c   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register; busy/done are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == RUN);
      done  <= (state_next == DONE);
    end
  end

  // Operand/result shift registers, borrow flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else if (load_c) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
    end else if (step_c) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= result_c;
      br     <= br_next_c;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result outputs load only on the final RUN edge and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
    end else if (finish_c) begin
      diff   <= result_c;
      borrow <= br_next_c;
      zero   <= (result_c == '0);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: self-checking bench for serial_subtractor (WIDTH=4).
// Expected results come from a plain arithmetic model, are queued when an
// operation is started and are popped when the done pulse is seen.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
  } res_t;

  res_t exp_q[$];
  res_t last;
  int   n_checks;
  int   n_pass;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    res_t r;
    int   full;
    full     = int'(x) - int'(y);
    r.diff   = WIDTH'(full + (1 << WIDTH));
    r.borrow = (full < 0);
    r.zero   = (full == 0);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    last  = '0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, borrow, zero} !== '0)
      $display("FAIL reset_async busy=%b done=%b diff=%b borrow=%b zero=%b, want all 0",
               busy, done, diff, borrow, zero);
    else n_pass++;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({busy, done, diff, borrow, zero} !== '0)
      $display("FAIL reset_release busy=%b done=%b diff=%b, want all 0", busy, done, diff);
    else n_pass++;
  endtask

  // Full operation with cycle-exact latency, hold and pulse-width checks.
  task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    res_t e;
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    exp_q.push_back(model(x, y));
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0 || {diff, borrow, zero} !== last)
        $display("FAIL %s_run%0d busy=%b done=%b out=%b, want busy=1 done=0 out=%b",
                 name, i, busy, done, {diff, borrow, zero}, last);
      else n_pass++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s_done_timing done=%b busy=%b, want done=1 busy=0", name, done, busy);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if ({diff, borrow, zero} !== e)
      $display("FAIL %s_result diff=%b borrow=%b zero=%b, want diff=%b borrow=%b zero=%b",
               name, diff, borrow, zero, e.diff, e.borrow, e.zero);
    else n_pass++;
    last = e;
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {diff, borrow, zero} !== last)
      $display("FAIL %s_after done=%b busy=%b out=%b, want done=0 busy=0 out=%b",
               name, done, busy, {diff, borrow, zero}, last);
    else n_pass++;
  endtask

  task automatic test_vectors();
    run_op("v_0011_0101", 4'b0011, 4'b0101);
    run_op("v_1100_0110", 4'b1100, 4'b0110);
    run_op("v_0000_0001", 4'b0000, 4'b0001);
    run_op("v_1111_1111", 4'b1111, 4'b1111);
    run_op("v_0000_1111", 4'b0000, 4'b1111);
    run_op("v_1111_0000", 4'b1111, 4'b0000);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_op($sformatf("rnd%0d", i), WIDTH'($urandom), WIDTH'($urandom));
  endtask

  task automatic test_start_during_run();
    res_t e;
    int   dones;
    @(posedge clk); #1;
    start = 1'b1; a = 4'b1100; b = 4'b0110;
    exp_q.push_back(model(4'b1100, 4'b0110));
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin start = 1'b1; a = 4'b0000; b = 4'b0000; end
      if (i == 2) start = 1'b0;
      if (busy === 1'b1 && {diff, borrow, zero} !== last) begin
        n_checks++;
        $display("FAIL sdr_hold%0d out=%b, want %b", i, {diff, borrow, zero}, last);
      end
      if (done === 1'b1) begin
        dones++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_checks++;
          if ({diff, borrow, zero} !== e)
            $display("FAIL sdr_result diff=%b borrow=%b zero=%b, want diff=%b borrow=%b zero=%b",
                     diff, borrow, zero, e.diff, e.borrow, e.zero);
          else n_pass++;
          n_checks++;
          if (i != int'(WIDTH))
            $display("FAIL sdr_latency done at cycle %0d, want %0d", i, WIDTH);
          else n_pass++;
          last = e;
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (dones != 1) $display("FAIL sdr_done_count got %0d, want 1", dones);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t e;
    int   gap;
    @(posedge clk); #1;
    start = 1'b1; a = 4'b1100; b = 4'b0110;
    exp_q.push_back(model(4'b1100, 4'b0110));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (WIDTH) begin @(posedge clk); #1; end
    n_checks++;
    if (done !== 1'b1) $display("FAIL b2b_first_done done=%b, want 1", done);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if ({diff, borrow, zero} !== e)
      $display("FAIL b2b_first_result out=%b, want %b", {diff, borrow, zero}, e);
    else n_pass++;
    last = e;
    start = 1'b1; a = 4'b0011; b = 4'b0101;
    exp_q.push_back(model(4'b0011, 4'b0101));
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || {diff, borrow, zero} !== last)
      $display("FAIL b2b_second_run busy=%b done=%b out=%b, want busy=1 done=0 out=%b",
               busy, done, {diff, borrow, zero}, last);
    else n_pass++;
    gap = 1;
    while (done !== 1'b1 && gap < 12) begin
      @(posedge clk); #1;
      gap++;
    end
    n_checks++;
    if (gap != int'(WIDTH) + 1) $display("FAIL b2b_gap got %0d cycles, want %0d", gap, WIDTH + 1);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (done !== 1'b1 || {diff, borrow, zero} !== e)
      $display("FAIL b2b_second_result done=%b out=%b, want done=1 out=%b",
               done, {diff, borrow, zero}, e);
    else n_pass++;
    last = e;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int bad;
    @(posedge clk); #1;
    start = 1'b1; a = 4'b1100; b = 4'b0110;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, diff, borrow, zero} !== '0)
      $display("FAIL rst_mid_run busy=%b done=%b diff=%b borrow=%b zero=%b, want all 0",
               busy, done, diff, borrow, zero);
    else n_pass++;
    last = '0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL rst_no_done %0d cycles with busy/done set, want 0", bad);
    else n_pass++;
    run_op("post_reset_1111_1111", 4'b1111, 4'b1111);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_vectors();
    test_random();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain %0d left, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand and result width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 The block SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request to begin a subtraction, sampled on rising clk.
REQ-005 The block SHALL have port a  input  WIDTH  minuend, unsigned, sampled when start is accepted.
REQ-006 The block SHALL have port b  input  WIDTH  subtrahend, unsigned, sampled when start is accepted.
REQ-007 The block SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-009 The block SHALL have port diff  output  WIDTH  registered result (a - b) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow  output  1  registered borrow-out; high iff a < b unsigned.
REQ-011 The block SHALL have port zero  output  1  registered flag; high iff diff == 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE: start=1 at a rising edge SHALL capture a and b into internal shift registers, clear the internal borrow flop and bit counter, and move to RUN; start=0 SHALL keep IDLE.
REQ-014 RUN SHALL process one bit per cycle, LSB first: d = a_i XOR b_i XOR br; br_next = (NOT a_i AND b_i) OR (NOT (a_i XOR b_i) AND br).
REQ-015 Each RUN cycle SHALL shift d into the MSB of an internal result shift register, shift the operand registers right by one, and increment the counter.
REQ-016 After exactly WIDTH RUN cycles the FSM SHALL move to DONE, loading diff, borrow (final br) and zero from internal state on that same edge.
REQ-017 DONE SHALL last exactly one cycle with done=1; the next state SHALL be RUN if start=1 (new operands captured, back-to-back), else IDLE.
REQ-018 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never be 1 together.
REQ-019 Latency: start accepted at edge T SHALL give busy=1 for cycles T..T+WIDTH-1 and done=1 in the cycle after edge T+WIDTH (WIDTH+1 cycles start-to-done).
REQ-020 start during RUN SHALL be ignored; operands and progress SHALL be unaffected.
REQ-021 Changes on a and b outside the accepting edge SHALL NOT affect the result.
REQ-022 diff, borrow and zero SHALL hold their last values from the end of DONE until the next DONE entry, including throughout RUN.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH with no saturation; a == b SHALL give diff=0, zero=1, borrow=0.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, and clear all internal registers.
REQ-025 Reset asserted mid-RUN or in DONE SHALL abandon the operation; no done pulse SHALL follow reset release.
REQ-026 After rst_n rises, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-027 WIDTH=4, a=0011, b=0101, start 1 cycle -> busy for 4 cycles, then done pulse with diff=1110, borrow=1, zero=0.
REQ-028 a=1100, b=0110 -> diff=0110, borrow=0, zero=0; a=0000, b=0001 -> diff=1111, borrow=1.
REQ-029 a=1111, b=1111 -> diff=0000, zero=1, borrow=0.
REQ-030 start pulsed again with a=0000, b=0000 during RUN of 1100-0110 -> ignored; single done with diff=0110; outputs unchanged during RUN.
REQ-031 start held high across DONE with new operands 0011/0101 -> second RUN begins the cycle after done; results 0110 then 1110, two done pulses 5 cycles apart.
REQ-032 rst_n pulsed low during the 3rd RUN cycle -> all outputs 0 at once, state IDLE, no done pulse; next start with 1111-1111 completes correctly.
